// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO block: output register with set/clear aliases, synchronized
// inputs, per-channel edge detection with sticky status and a level interrupt.
module mmio_gpio #(
  parameter int unsigned WIDTH     = 10,
  parameter logic [15:0] BASE_ADDR = 16'hC000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [15:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             irq
);

  localparam int unsigned DW = 16;

  localparam logic [2:0] OFF_OUT      = 3'd0;
  localparam logic [2:0] OFF_IN       = 3'd1;
  localparam logic [2:0] OFF_EDGE_EN  = 3'd2;
  localparam logic [2:0] OFF_EDGE_POL = 3'd3;
  localparam logic [2:0] OFF_EDGE_ST  = 3'd4;
  localparam logic [2:0] OFF_OUT_SET  = 3'd5;
  localparam logic [2:0] OFF_OUT_CLR  = 3'd6;

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] edge_en;
  logic [WIDTH-1:0] edge_pol;
  logic [WIDTH-1:0] edge_stat;
  logic [WIDTH-1:0] s1, s2, s3;

  logic             sel;
  logic             wr;
  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] stat_clr;
  logic [WIDTH-1:0] stat_next;
  logic [WIDTH-1:0] out_next;

  // Only the low WIDTH bits of wdata carry register content.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign sel  = (addr[15:3] == BASE_ADDR[15:3]);
  assign wr   = we && sel;
  assign wval = wdata[WIDTH-1:0];

  assign gpio_out = out_reg;

  // Edge detect, sticky status update and output register next value.
  always_comb begin
    edge_det  = (s2 & ~s3 & ~edge_pol) | (~s2 & s3 & edge_pol);
    stat_clr  = '0;
    out_next  = out_reg;
    if (wr) begin
      case (addr[2:0])
        OFF_OUT:     out_next = wval;
        OFF_OUT_SET: out_next = out_reg | wval;
        OFF_OUT_CLR: out_next = out_reg & ~wval;
        OFF_EDGE_ST: stat_clr = wval;
        default:     out_next = out_reg;
      endcase
    end
    // A new edge on a bit being cleared in the same cycle keeps the bit set.
    stat_next = (edge_stat & ~stat_clr) | (edge_det & edge_en);
  end

  // Register file, input synchronizer chain and registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= '0;
      edge_en   <= '0;
      edge_pol  <= '0;
      edge_stat <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      irq       <= 1'b0;
    end else begin
      s1        <= gpio_in;
      s2        <= s1;
      s3        <= s2;
      out_reg   <= out_next;
      edge_stat <= stat_next;
      irq       <= |stat_next;
      if (wr && addr[2:0] == OFF_EDGE_EN)  edge_en  <= wval;
      if (wr && addr[2:0] == OFF_EDGE_POL) edge_pol <= wval;
    end
  end

  // Zero-latency read mux; idle or unselected bus reads as zero.
  always_comb begin
    rdata = '0;
    if (re && sel) begin
      case (addr[2:0])
        OFF_OUT:      rdata = DW'(out_reg);
        OFF_IN:       rdata = DW'(s2);
        OFF_EDGE_EN:  rdata = DW'(edge_en);
        OFF_EDGE_POL: rdata = DW'(edge_pol);
        OFF_EDGE_ST:  rdata = DW'(edge_stat);
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed self-checking bench for mmio_gpio (WIDTH=10, BASE=16'hC000).
module tb_mmio_gpio;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        re;
  logic [15:0] rdata;
  logic [9:0]  gpio_in;
  logic [9:0]  gpio_out;
  logic        irq;

  int checks;
  int failures;

  mmio_gpio #(.WIDTH(10), .BASE_ADDR(16'hC000)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = 16'h0;
    wdata = 16'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr = a;
    re   = 1'b1;
    #1;
    chk(tag, rdata, exp);
    re   = 1'b0;
    addr = 16'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    addr     = 16'h0;
    wdata    = 16'h0;
    we       = 1'b0;
    re       = 1'b0;
    gpio_in  = 10'h000;

    // Reset, with a write attempted while reset is high.
    tick();
    tick();
    bus_wr(16'hC000, 16'h03FF);
    chk("rst_gpio_out", 16'(gpio_out), 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    rd_chk("rst_stat", 16'hC004, 16'h0000);
    rst = 1'b0;

    // OUT register, set/clear aliases.
    bus_wr(16'hC000, 16'h03FF);
    chk("out_write", 16'(gpio_out), 16'h03FF);
    bus_wr(16'hC006, 16'h0005);
    chk("out_clr", 16'(gpio_out), 16'h03FA);
    rd_chk("out_read", 16'hC000, 16'h03FA);
    rd_chk("clr_reads0", 16'hC006, 16'h0000);
    bus_wr(16'hC005, 16'h0004);
    chk("out_set", 16'(gpio_out), 16'h03FE);
    rd_chk("set_reads0", 16'hC005, 16'h0000);

    // Out-of-window and read-only/reserved accesses.
    bus_wr(16'hC008, 16'hFFFF);
    chk("oow_out", 16'(gpio_out), 16'h03FE);
    rd_chk("oow_en", 16'hC002, 16'h0000);
    rd_chk("oow_read", 16'hC008, 16'h0000);
    addr = 16'hC000;
    #1;
    chk("no_re_zero", rdata, 16'h0000);
    addr = 16'h0;
    bus_wr(16'hC001, 16'h03FF);
    bus_wr(16'hC007, 16'h03FF);
    rd_chk("in_ro", 16'hC001, 16'h0000);
    rd_chk("rsvd_read", 16'hC007, 16'h0000);
    chk("rsvd_out", 16'(gpio_out), 16'h03FE);

    // Rising edge on channel 0, then write-1-to-clear.
    bus_wr(16'hC002, 16'h0001);
    gpio_in = 10'h001;
    tick();
    tick();
    chk("edge_n1_irq", 16'(irq), 16'h0000);
    rd_chk("in_latency", 16'hC001, 16'h0001);
    tick();
    chk("edge_irq", 16'(irq), 16'h0001);
    rd_chk("edge_stat", 16'hC004, 16'h0001);
    bus_wr(16'hC004, 16'h0001);
    chk("w1c_irq", 16'(irq), 16'h0000);
    rd_chk("w1c_stat", 16'hC004, 16'h0000);

    // Polarity change alone does not set status.
    bus_wr(16'hC003, 16'h0001);
    tick();
    tick();
    rd_chk("pol_nochg", 16'hC004, 16'h0000);
    bus_wr(16'hC003, 16'h0000);

    // Disabled channel never sets.
    gpio_in = 10'h003;
    tick();
    tick();
    tick();
    rd_chk("dis_chan", 16'hC004, 16'h0000);

    // Channel 3 falling polarity; new edge beats same-cycle clear.
    bus_wr(16'hC002, 16'h0009);
    bus_wr(16'hC003, 16'h0008);
    gpio_in = 10'h00B;
    tick();
    tick();
    tick();
    rd_chk("rise_on_fall", 16'hC004, 16'h0000);
    gpio_in = 10'h003;
    tick();
    tick();
    bus_wr(16'hC004, 16'h0008);
    rd_chk("edge_wins", 16'hC004, 16'h0008);
    chk("edge_wins_irq", 16'(irq), 16'h0001);
    bus_wr(16'hC004, 16'h0008);
    rd_chk("clr3", 16'hC004, 16'h0000);
    chk("clr3_irq", 16'(irq), 16'h0000);

    // Reset with OUT full and status pending.
    gpio_in = 10'h002;
    tick();
    tick();
    tick();
    gpio_in = 10'h003;
    tick();
    tick();
    tick();
    rd_chk("pre_rst_stat", 16'hC004, 16'h0001);
    bus_wr(16'hC000, 16'h03FF);
    chk("pre_rst_out", 16'(gpio_out), 16'h03FF);
    rst = 1'b1;
    tick();
    chk("rst2_out", 16'(gpio_out), 16'h0000);
    chk("rst2_irq", 16'(irq), 16'h0000);
    rd_chk("rst2_en", 16'hC002, 16'h0000);

    // Input held through reset release shows as rising edges.
    gpio_in = 10'h2A5;
    tick();
    rst = 1'b0;
    rd_chk("in_pre", 16'hC001, 16'h0000);
    bus_wr(16'hC002, 16'h03FF);
    rd_chk("in_after1", 16'hC001, 16'h0000);
    chk("irq_after1", 16'(irq), 16'h0000);
    tick();
    rd_chk("in_after2", 16'hC001, 16'h02A5);
    chk("irq_after2", 16'(irq), 16'h0000);
    tick();
    rd_chk("first_edge", 16'hC004, 16'h02A5);
    chk("first_irq", 16'(irq), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
